// File: rtl/click_pkg.sv
// Shared definitions for the click classifier.
// Holds the FSM state encoding and the click-count values used to decide
// which strobe is raised when a burst finishes.
package click_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        EMIT     = 2'd2
    } click_state_e;

    localparam logic [1:0] CLICK_SINGLE = 2'd1;
    localparam logic [1:0] CLICK_DOUBLE = 2'd2;
    localparam logic [1:0] CLICK_TRIPLE = 2'd3;

endpackage

// File: rtl/click_classifier_if.sv
// Click classifier event interface.
// Signals:
//   press_pulse  - one-cycle press strobe from the debouncer
//   single_click - one-cycle strobe, burst of exactly 1 press
//   double_click - one-cycle strobe, burst of exactly 2 presses
//   triple_click - one-cycle strobe, burst of 3 presses
//   busy         - high while a burst is being timed or emitted
//   click_count  - presses counted in the current burst
// Modports: master drives press_pulse (debouncer side), slave is the classifier.
interface click_classifier_if;

    logic       press_pulse;
    logic       single_click;
    logic       double_click;
    logic       triple_click;
    logic       busy;
    logic [1:0] click_count;

    modport master (
        output press_pulse,
        input  single_click,
        input  double_click,
        input  triple_click,
        input  busy,
        input  click_count
    );

    modport slave (
        input  press_pulse,
        output single_click,
        output double_click,
        output triple_click,
        output busy,
        output click_count
    );

endinterface

// File: rtl/click_classifier.sv
// Classifies bursts of debounced press pulses into single, double or triple
// clicks. Every press restarts an inter-press window; when the window
// expires, or a third press arrives, one classification strobe is emitted.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-low reset
//   bus   - click_classifier_if.slave (press input, strobes, busy, count)
module click_classifier
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 25000000,
    parameter int unsigned TIMER_WIDTH   = 25
) (
    input logic               clock,
    input logic               reset,
    click_classifier_if.slave bus
);

    localparam logic [TIMER_WIDTH-1:0] TimerLast = TIMER_WIDTH'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TimerOne  = TIMER_WIDTH'(1);

    click_state_e           state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [1:0]             count_q, count_d;
    logic                   single_q, single_d;
    logic                   double_q, double_d;
    logic                   triple_q, triple_d;
    logic                   busy_q, busy_d;

    logic press;
    logic timeout;

    assign press   = bus.press_pulse;
    assign timeout = (timer_q == TimerLast);

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            single_q <= single_d;
            double_q <= double_d;
            triple_q <= triple_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state, timer and press counter.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (press) begin
                    state_d = COUNTING;
                    count_d = CLICK_SINGLE;
                end
            end
            COUNTING: begin
                timer_d = timer_q + TimerOne;
                // A press always beats a coincident timeout.
                if (press) begin
                    timer_d = '0;
                    if (count_q == CLICK_DOUBLE) begin
                        state_d = EMIT;
                        count_d = CLICK_TRIPLE;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end else if (timeout) begin
                    state_d = EMIT;
                    timer_d = '0;
                end
            end
            EMIT: begin
                // A press here opens a new burst rather than being dropped.
                if (press) begin
                    state_d = COUNTING;
                    count_d = CLICK_SINGLE;
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Registered outputs: strobes are set on the edge that enters EMIT.
    always_comb begin
        single_d = 1'b0;
        double_d = 1'b0;
        triple_d = 1'b0;
        if (state_q == COUNTING) begin
            if (press) begin
                triple_d = (count_q == CLICK_DOUBLE);
            end else if (timeout) begin
                single_d = (count_q == CLICK_SINGLE);
                double_d = (count_q == CLICK_DOUBLE);
            end
        end
        busy_d = (state_d != IDLE);
    end

    assign bus.single_click = single_q;
    assign bus.double_click = double_q;
    assign bus.triple_click = triple_q;
    assign bus.busy         = busy_q;
    assign bus.click_count  = count_q;

endmodule

// File: tb/tb_click_classifier.sv
// Self-checking bench for click_classifier with a short click window.
module tb_click_classifier;

    localparam int unsigned W  = 10;
    localparam int unsigned TW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    click_classifier_if bus();

    click_classifier #(
        .WINDOW_CYCLES(W),
        .TIMER_WIDTH  (TW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: burst described by press count and age since last press.
    bit m_burst;
    int m_n;
    int m_age;
    int m_emit;

    task automatic model_step(input bit p, input bit r);
        if (!r) begin
            m_burst = 0; m_n = 0; m_age = 0; m_emit = 0;
        end else if (m_emit != 0) begin
            m_emit = 0;
            if (p) begin
                m_burst = 1; m_n = 1; m_age = 0;
            end else begin
                m_burst = 0; m_n = 0;
            end
        end else if (m_burst) begin
            if (p) begin
                m_n++;
                m_age = 0;
                if (m_n == 3) begin
                    m_emit = 3; m_burst = 0;
                end
            end else begin
                m_age++;
                if (m_age == int'(W)) begin
                    m_emit = m_n; m_burst = 0;
                end
            end
        end else if (p) begin
            m_burst = 1; m_n = 1; m_age = 0;
        end
    endtask

    function automatic logic [5:0] model_out();
        logic [1:0] cnt;
        cnt = m_n[1:0];
        return {m_emit == 1, m_emit == 2, m_emit == 3, (m_burst || m_emit != 0), cnt};
    endfunction

    function automatic logic [5:0] dut_out();
        return {bus.single_click, bus.double_click, bus.triple_click, bus.busy, bus.click_count};
    endfunction

    // Drive inputs away from the edge, clock once, then sample 1 ns later.
    task automatic apply(input bit p, input bit r);
        bus.press_pulse = p;
        reset = r;
        @(posedge clock);
        model_step(p, r);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = dut_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got s/d/t/busy/cnt=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit         press;
        bit         rst;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int lat;
        int other;

        bus.press_pulse = 1'b0;
        m_burst = 0; m_n = 0; m_age = 0; m_emit = 0;

        // Triple burst, new burst, then reset mid-burst.  exp = {s,d,t,busy,cnt}
        tbl[0]  = '{press: 1'b0, rst: 1'b0, exp: 6'b000000};
        tbl[1]  = '{press: 1'b0, rst: 1'b1, exp: 6'b000000};
        tbl[2]  = '{press: 1'b1, rst: 1'b1, exp: 6'b000101};
        tbl[3]  = '{press: 1'b0, rst: 1'b1, exp: 6'b000101};
        tbl[4]  = '{press: 1'b1, rst: 1'b1, exp: 6'b000110};
        tbl[5]  = '{press: 1'b0, rst: 1'b1, exp: 6'b000110};
        tbl[6]  = '{press: 1'b1, rst: 1'b1, exp: 6'b001111};
        tbl[7]  = '{press: 1'b0, rst: 1'b1, exp: 6'b000000};
        tbl[8]  = '{press: 1'b1, rst: 1'b1, exp: 6'b000101};
        tbl[9]  = '{press: 1'b0, rst: 1'b0, exp: 6'b000000};
        tbl[10] = '{press: 1'b0, rst: 1'b1, exp: 6'b000000};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].press, tbl[i].rst);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Single press: strobe exactly W edges after the press edge.
        apply(1'b1, 1'b1);
        check("single_start", model_out());
        lat = -1; other = 0;
        for (int i = 1; i <= 25; i++) begin
            apply(1'b0, 1'b1);
            check("single_seq", model_out());
            if (bus.single_click && lat < 0) lat = i;
            if (bus.double_click || bus.triple_click) other++;
        end
        check_int("single_latency", lat, int'(W));
        check_int("single_no_other", other, 0);

        // Press coinciding with timeout is counted; double follows W edges later.
        apply(1'b1, 1'b1);
        for (int i = 0; i < int'(W) - 1; i++) begin
            apply(1'b0, 1'b1);
            check("collision_wait", model_out());
        end
        apply(1'b1, 1'b1);
        check("collision_press", model_out());
        lat = -1; other = 0;
        for (int i = 1; i <= 25; i++) begin
            apply(1'b0, 1'b1);
            check("collision_seq", model_out());
            if (bus.double_click && lat < 0) lat = i;
            if (bus.single_click) other++;
        end
        check_int("collision_double_latency", lat, int'(W));
        check_int("collision_no_single", other, 0);

        // Press on the strobe cycle starts a new burst.
        apply(1'b1, 1'b1);
        for (int i = 0; i < int'(W); i++) apply(1'b0, 1'b1);
        check("emit_single", model_out());
        apply(1'b1, 1'b1);
        check("emit_press_newburst", model_out());
        check_int("emit_press_count", int'(bus.click_count), 1);
        lat = -1;
        for (int i = 1; i <= 25; i++) begin
            apply(1'b0, 1'b1);
            check("emit_press_seq", model_out());
            if (bus.single_click && lat < 0) lat = i;
        end
        check_int("emit_second_single_latency", lat, int'(W));

        // Reset mid-burst drops the burst silently.
        apply(1'b1, 1'b1);
        apply(1'b0, 1'b1);
        apply(1'b1, 1'b1);
        apply(1'b0, 1'b0);
        check("reset_mid_burst", 6'b000000);
        other = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'b1);
            check("reset_quiet", model_out());
            if (bus.single_click || bus.double_click || bus.triple_click) other++;
        end
        check_int("reset_no_strobe", other, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit p;
            bit r;
            p = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 299) != 0);
            apply(p, r);
            check("random", model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
